// File: rtl/text_console.sv
// Character console: turns an ASCII byte stream into screen-buffer writes, cursor moves and line clears.
// Latency: a printable byte is written one cycle after acceptance; redraw follows the last write by one cycle.
// Backpressure: in_ready is high only when idle. Scroll-on-last-row is enabled by TEXT_CONSOLE_SCROLL_EN.
module text_console #(
    parameter int         COLS  = 40,
    parameter int         ROWS  = 30,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        buf_wr,
    output logic [10:0] buf_addr,
    output logic [7:0]  buf_data,
    output logic [10:0] buf_rd_addr,
    input  logic [7:0]  buf_rd_data,
    output logic [5:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        redraw
);
    localparam logic [5:0]  LAST_COL = 6'(COLS - 1);
    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
    localparam logic [10:0] COLS_W   = 11'(COLS);

    typedef enum logic [1:0] {
        IDLE,
        PUT,
        CLEAR
`ifdef TEXT_CONSOLE_SCROLL_EN
        , SCROLL
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [7:0]  put_dat_q, put_dat_d;
    logic        put_adv_q, put_adv_d;
    logic [5:0]  clr_q, clr_d;
    logic        redraw_q, redraw_d;
    logic        rdy_en_q;
    logic        accept;
    logic        newline;
    logic [10:0] row_base;

`ifdef TEXT_CONSOLE_SCROLL_EN
    localparam logic [10:0] LAST_CELL = 11'(COLS * ROWS - 1);
    logic [10:0] rd_addr_q, rd_addr_d;
    logic        rd_act_q, rd_act_d;
    logic        pend_q, pend_d;
    logic [10:0] wr_addr_q, wr_addr_d;
`else
    logic unused_rd_data;
    assign unused_rd_data = ^buf_rd_data;
`endif

    assign row_base = 11'(row_q) * COLS_W;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        put_dat_d = put_dat_q;
        put_adv_d = put_adv_q;
        clr_d     = clr_q;
        redraw_d  = 1'b0;
        newline   = 1'b0;
        buf_wr    = 1'b0;
        buf_addr  = row_base + 11'(col_q);
        buf_data  = put_dat_q;
`ifdef TEXT_CONSOLE_SCROLL_EN
        rd_addr_d = rd_addr_q;
        rd_act_d  = rd_act_q;
        pend_d    = pend_q;
        wr_addr_d = wr_addr_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        put_dat_d = in_data;
                        put_adv_d = 1'b1;
                        state_d   = PUT;
                    end else if (in_data == 8'h0A) begin
                        col_d   = 6'd0;
                        newline = 1'b1;
                    end else if (in_data == 8'h0D) begin
                        col_d = 6'd0;
                    end else if (in_data == 8'h08 && col_q != 6'd0) begin
                        // Backspace blanks the cell it moves onto, cursor stays there.
                        col_d     = col_q - 6'd1;
                        put_dat_d = BLANK;
                        put_adv_d = 1'b0;
                        state_d   = PUT;
                    end
                end
            end
            PUT: begin
                buf_wr = 1'b1;
                if (put_adv_q && col_q == LAST_COL) begin
                    col_d   = 6'd0;
                    newline = 1'b1;
                end else begin
                    if (put_adv_q) begin
                        col_d = col_q + 6'd1;
                    end
                    state_d  = IDLE;
                    redraw_d = 1'b1;
                end
            end
            CLEAR: begin
                buf_wr   = 1'b1;
                buf_addr = row_base + 11'(clr_q);
                buf_data = BLANK;
                if (clr_q == LAST_COL) begin
                    clr_d    = 6'd0;
                    state_d  = IDLE;
                    redraw_d = 1'b1;
                end else begin
                    clr_d = clr_q + 6'd1;
                end
            end
`ifdef TEXT_CONSOLE_SCROLL_EN
            SCROLL: begin
                // Read of cell i is issued one cycle before its copy lands at i-COLS.
                buf_wr    = pend_q;
                buf_addr  = wr_addr_q;
                buf_data  = buf_rd_data;
                pend_d    = rd_act_q;
                wr_addr_d = rd_addr_q - COLS_W;
                if (rd_act_q) begin
                    if (rd_addr_q == LAST_CELL) begin
                        rd_act_d  = 1'b0;
                        rd_addr_d = 11'd0;
                    end else begin
                        rd_addr_d = rd_addr_q + 11'd1;
                    end
                end else if (pend_q) begin
                    clr_d   = 6'd0;
                    state_d = CLEAR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (newline) begin
            clr_d = 6'd0;
            if (row_q != LAST_ROW) begin
                row_d   = row_q + 5'd1;
                state_d = CLEAR;
            end else begin
`ifdef TEXT_CONSOLE_SCROLL_EN
                rd_addr_d = COLS_W;
                rd_act_d  = 1'b1;
                pend_d    = 1'b0;
                state_d   = SCROLL;
`else
                row_d   = 5'd0;
                state_d = CLEAR;
`endif
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_q     <= 6'd0;
            row_q     <= 5'd0;
            put_dat_q <= 8'd0;
            put_adv_q <= 1'b0;
            clr_q     <= 6'd0;
            redraw_q  <= 1'b0;
            rdy_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            put_dat_q <= put_dat_d;
            put_adv_q <= put_adv_d;
            clr_q     <= clr_d;
            redraw_q  <= redraw_d;
            rdy_en_q  <= 1'b1;
        end
    end

`ifdef TEXT_CONSOLE_SCROLL_EN
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= 11'd0;
            rd_act_q  <= 1'b0;
            pend_q    <= 1'b0;
            wr_addr_q <= 11'd0;
        end else begin
            rd_addr_q <= rd_addr_d;
            rd_act_q  <= rd_act_d;
            pend_q    <= pend_d;
            wr_addr_q <= wr_addr_d;
        end
    end
    assign buf_rd_addr = rd_addr_q;
`else
    assign buf_rd_addr = 11'd0;
`endif

    // rdy_en_q keeps in_ready low through reset and releases it one clock later.
    assign in_ready   = rdy_en_q && (state_q == IDLE);
    assign redraw     = redraw_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_text_console.sv
// Directed self-checking bench for text_console with a behavioural screen-buffer model.
module tb_text_console;
    logic        clk_sys  = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic        in_ready;
    logic        buf_wr;
    logic [10:0] buf_addr;
    logic [7:0]  buf_data;
    logic [10:0] buf_rd_addr;
    logic [7:0]  buf_rd_data;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        redraw;

    text_console dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .buf_wr      (buf_wr),
        .buf_addr    (buf_addr),
        .buf_data    (buf_data),
        .buf_rd_addr (buf_rd_addr),
        .buf_rd_data (buf_rd_data),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .redraw      (redraw)
    );

    always #5 clk_sys = ~clk_sys;

    logic [7:0] mem [0:1199];
    logic [7:0] rd_pend;
    int cyc = 0, wr_cnt = 0, rd_cnt = 0, acc_cnt = 0, bad_ready = 0;
    int first_wr_addr = 0, last_wr_addr = 0, max_wr_addr = 0;
    int first_wr_cyc = 0, last_wr_cyc = 0, last_rd_cyc = 0, last_acc_cyc = 0;
    int n_checks = 0, n_fails = 0;

    // Inputs change just after posedges, so the falling edge sees stable values.
    always @(negedge clk_sys) begin
        cyc++;
        rd_pend = mem[buf_rd_addr];
        if (buf_wr) begin
            if (wr_cnt == 0) begin
                first_wr_addr = int'(buf_addr);
                first_wr_cyc  = cyc;
            end
            if (int'(buf_addr) > max_wr_addr) max_wr_addr = int'(buf_addr);
            wr_cnt++;
            last_wr_addr = int'(buf_addr);
            last_wr_cyc  = cyc;
            if (buf_addr < 11'd1200) mem[buf_addr] = buf_data;
            if (in_ready) bad_ready++;
        end
        if (redraw) begin
            rd_cnt++;
            last_rd_cyc = cyc;
        end
        if (in_valid && in_ready) begin
            acc_cnt++;
            last_acc_cyc = cyc;
        end
    end

    always @(posedge clk_sys) buf_rd_data <= rd_pend;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic clr();
        wr_cnt = 0; rd_cnt = 0; acc_cnt = 0; bad_ready = 0; max_wr_addr = 0;
    endtask

    task automatic xfer(input logic [7:0] b, input bit hold);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        check("send_ready", in_ready, 1);
        tick();
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        xfer(b, 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (in_ready !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        check("idle_timeout", in_ready, 1);
        tick();
        tick();
    endtask

    task automatic goto_last_row();
        for (int i = 0; i < 40 && cursor_row != 5'd29; i++) send(8'h0A);
        wait_idle();
    endtask

    initial begin
        for (int i = 0; i < 1200; i++) mem[i] = 8'hEE;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_buf_wr", buf_wr, 0);
        check("rst_redraw", redraw, 0);
        check("rst_col", cursor_col, 0);
        check("rst_row", cursor_row, 0);
        check("rst_rd_addr", buf_rd_addr, 0);
        tick();
        rst_n = 1'b1;
        check("rel_ready_low", in_ready, 0);
        tick();
        check("rel_ready_high", in_ready, 1);

        // Single printable byte
        clr();
        send(8'h41);
        wait_idle();
        check("a_wr_cnt", wr_cnt, 1);
        check("a_addr", first_wr_addr, 0);
        check("a_data", mem[0], 8'h41);
        check("a_wr_latency", first_wr_cyc, last_acc_cyc + 1);
        check("a_redraw_cnt", rd_cnt, 1);
        check("a_redraw_cyc", last_rd_cyc, last_wr_cyc + 1);
        check("a_col", cursor_col, 1);
        check("a_row", cursor_row, 0);

        // Full line with wrap and clear of the next row
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        clr();
        for (int i = 0; i < 40; i++) send(8'h42);
        wait_idle();
        check("b_wr_cnt", wr_cnt, 80);
        check("b_first", first_wr_addr, 0);
        check("b_last", last_wr_addr, 79);
        check("b_mem0", mem[0], 8'h42);
        check("b_mem39", mem[39], 8'h42);
        check("b_mem40", mem[40], 8'h20);
        check("b_mem79", mem[79], 8'h20);
        check("b_redraw", rd_cnt, 40);
        check("b_row", cursor_row, 1);
        check("b_col", cursor_col, 0);

        // Backspace, ignored control and carriage return
        clr();
        send(8'h08);
        wait_idle();
        check("bs0_wr", wr_cnt, 0);
        check("bs0_redraw", rd_cnt, 0);
        check("bs0_col", cursor_col, 0);
        for (int i = 0; i < 5; i++) send(8'h63);
        wait_idle();
        check("c_col", cursor_col, 5);
        clr();
        send(8'h08);
        wait_idle();
        check("bs5_wr", wr_cnt, 1);
        check("bs5_addr", last_wr_addr, 44);
        check("bs5_data", mem[44], 8'h20);
        check("bs5_col", cursor_col, 4);
        check("bs5_redraw", rd_cnt, 1);
        clr();
        send(8'h01);
        wait_idle();
        check("ign_wr", wr_cnt, 0);
        check("ign_redraw", rd_cnt, 0);
        check("ign_col", cursor_col, 4);
        send(8'h0D);
        wait_idle();
        check("cr_wr", wr_cnt, 0);
        check("cr_redraw", rd_cnt, 0);
        check("cr_col", cursor_col, 0);
        check("cr_row", cursor_row, 1);

        // Bytes held upstream while a clear is running
        clr();
        xfer(8'h0A, 1'b1);
        xfer(8'h07, 1'b1);
        xfer(8'h78, 1'b1);
        xfer(8'h79, 1'b0);
        wait_idle();
        check("hold_acc", acc_cnt, 4);
        check("hold_wr", wr_cnt, 42);
        check("hold_ready_busy", bad_ready, 0);
        check("hold_x", mem[80], 8'h78);
        check("hold_y", mem[81], 8'h79);
        check("hold_blank", mem[119], 8'h20);
        check("hold_redraw", rd_cnt, 3);
        check("hold_col", cursor_col, 2);
        check("hold_row", cursor_row, 2);

        // Newline on the last row
        goto_last_row();
        check("last_row", cursor_row, 29);
        send(8'h5A);
        send(8'h0D);
        wait_idle();
        clr();
        send(8'h0A);
        wait_idle();
        check("nl_redraw", rd_cnt, 1);
        check("nl_first", first_wr_addr, 0);
        check("nl_col", cursor_col, 0);
`ifdef TEXT_CONSOLE_SCROLL_EN
        check("sc_wr_cnt", wr_cnt, 1200);
        check("sc_last", last_wr_addr, 1199);
        check("sc_max", max_wr_addr, 1199);
        check("sc_mem0", mem[0], 8'h63);
        check("sc_mem4", mem[4], 8'h20);
        check("sc_mem40", mem[40], 8'h78);
        check("sc_mem1120", mem[1120], 8'h5A);
        check("sc_mem1160", mem[1160], 8'h20);
        check("sc_row", cursor_row, 29);
`else
        check("wrap_wr_cnt", wr_cnt, 40);
        check("wrap_last", last_wr_addr, 39);
        check("wrap_max", max_wr_addr, 39);
        check("wrap_mem0", mem[0], 8'h20);
        check("wrap_mem40", mem[40], 8'h63);
        check("wrap_row", cursor_row, 0);
`endif

        // Reset in the middle of the last-row operation
        goto_last_row();
        send(8'h0A);
        repeat (20) tick();
        check("mid_wr_active", buf_wr, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr", buf_wr, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_redraw", redraw, 0);
        check("mid_rst_col", cursor_col, 0);
        check("mid_rst_row", cursor_row, 0);
        check("mid_rst_rd_addr", buf_rd_addr, 0);
        tick();
        rst_n = 1'b1;
        check("mid_rel_low", in_ready, 0);
        tick();
        check("mid_rel_high", in_ready, 1);
        clr();
        repeat (50) tick();
        check("mid_no_cleanup", wr_cnt, 0);
        check("mid_no_redraw", rd_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/text_console.md
TEXT_CONSOLE -- requirements
Module: text_console

Interface
REQ-001 Parameter COLS, default 40: character columns in the screen buffer.
REQ-002 Parameter ROWS, default 30: character rows; COLS*ROWS = 1200 buffer cells.
REQ-003 Parameter BLANK, default 8'h20: fill byte used for clears.
REQ-004 clk_sys  in  1  system clock; all logic on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  upstream byte valid.
REQ-007 in_data  in  8  upstream ASCII byte.
REQ-008 in_ready  out  1  console can accept a byte this cycle.
REQ-009 buf_wr  out  1  screen-buffer write strobe, one cell per cycle.
REQ-010 buf_addr  out  11  write cell index = row*COLS + col.
REQ-011 buf_data  out  8  write byte.
REQ-012 buf_rd_addr  out  11  screen-buffer read index.
REQ-013 buf_rd_data  in  8  read byte, valid one cycle after buf_rd_addr.
REQ-014 cursor_col  out  6  current column, 0..COLS-1.
REQ-015 cursor_row  out  5  current row, 0..ROWS-1.
REQ-016 redraw  out  1  one-cycle pulse: buffer changed, renderer shall rescan.

Function
REQ-017 States: IDLE, PUT, CLEAR, SCROLL; in_ready SHALL be 1 only in IDLE.
REQ-018 Handshake: a byte transfers when in_valid && in_ready; bytes offered outside IDLE stay held upstream and are not lost.
REQ-019 Printable bytes (0x20..0x7E) go to PUT: buf_wr=1 the cycle after acceptance, addr = cursor, data = byte; then col+1.
REQ-020 Column wrap: a write at col COLS-1 sets col=0 and performs a newline.
REQ-021 LF (0x0A): col=0, newline. CR (0x0D): col=0, no write, no redraw.
REQ-022 BS (0x08): if col>0, col-1 and write BLANK at the new cursor; at col 0, no-op.
REQ-023 All other bytes are accepted and ignored: no write, no cursor change, no redraw.
REQ-024 Newline with row<ROWS-1: row+1, then CLEAR writes BLANK to the new row, cols 0..COLS-1, one cell per cycle (COLS cycles).
REQ-025 Newline with row=ROWS-1 is governed by REQ-032/REQ-033.
REQ-026 redraw pulses exactly once, in the cycle after the last buffer write of an operation; returning to IDLE happens in that same cycle.
REQ-027 buf_addr arithmetic is 11-bit unsigned; the maximum index is 1199 and never exceeded.
REQ-028 buf_wr is 0 whenever no write is performed; buf_addr/buf_data are don't-care when buf_wr=0.

Reset
REQ-029 Assertion of rst_n=0 at any time, including mid-CLEAR or mid-SCROLL, immediately forces: state IDLE, cursor 0/0, buf_wr=0, redraw=0, in_ready=0, buf_rd_addr=0.
REQ-030 in_ready rises the first clock after rst_n deasserts; a partially cleared or scrolled buffer is left as is, and no cleanup writes are issued.
REQ-031 No buffer initialisation on reset; the buffer's owner clears it.

Configuration
REQ-032 Macro TEXT_CONSOLE_SCROLL_EN defined: newline at the last row enters SCROLL; for i=COLS..1199 it drives buf_rd_addr=i and writes the returned byte to i-COLS the next cycle (pipelined, one cell per cycle); it then CLEARs row ROWS-1; row stays ROWS-1.
REQ-033 Macro undefined: newline at the last row sets row=0 and CLEARs row 0; the SCROLL state is absent and buf_rd_addr is tied to 0.

Verification
REQ-034 Reset, then 'A' (0x41) at 0/0 -> buf_wr once, addr 0, data 0x41, the next cycle redraw=1; cursor 0/1.
REQ-035 Send 40 x 'B' from 0/0 -> writes to addrs 0..39, then BLANK writes to 40..79; cursor row 1, col 0; one redraw per byte.
REQ-036 Send BS at col 0 -> no write or redraw; at col 5 -> BLANK written at col 4, cursor col 4.
REQ-037 Cursor at row 29, send LF, macro defined -> 1160 copy writes (1199 to 1159) plus 40 BLANK writes at 1160..1199; row stays 29. Macro undefined -> 40 BLANK writes at 0..39; row 0.
REQ-038 Pulse rst_n low midway through REQ-037 -> buf_wr drops in the same cycle; cursor 0/0; in_ready=1 one cycle after release.
REQ-039 Hold in_valid with 0x07 and random bytes during CLEAR -> in_ready stays 0; every byte is consumed once, in order; 0x07 causes no write.
